feature_quantizer_3b: RTL and testbench

//  Streaming quantizer that produces the 3-bit feature codes consumed by the approximate 3-bit

---
 rtl/fq_pkg.sv | 23 ++
 rtl/fq_thr_bank.sv | 54 +++++
 rtl/feature_quantizer_3b.sv | 166 ++++++++++++++++
 tb/tb_feature_quantizer_3b.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fq_pkg.sv
// Shared types and constants for the 3-bit feature quantizer.
// The optional statistics block is enabled with the FQ_STATS_EN macro.
package fq_pkg;

    localparam int unsigned CODE_W  = 3;
    localparam int unsigned NUM_THR = 7;
    localparam int unsigned STAT_W  = 16;

    // Successive-approximation search: one state per code bit, MSB first.
    typedef enum logic [2:0] {
        IDLE,
        S2,
        S1,
        S0,
        OUT
    } fq_state_t;

    // Increment that sticks at all-ones.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/fq_thr_bank.sv
// Per-feature threshold register file: NUM_FEAT sets of NUM_THR thresholds.
// Thresholds are addressed 1..7; index 0 and out-of-range features are ignored
// on write and read back as zero.
module fq_thr_bank
    import fq_pkg::*;
#(
    parameter int unsigned IN_W     = 8,
    parameter int unsigned NUM_FEAT = 11,
    parameter int unsigned FEAT_W   = $clog2(NUM_FEAT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [FEAT_W-1:0] wr_feat,
    input  logic [2:0]        wr_idx,
    input  logic [IN_W-1:0]   wr_data,
    input  logic [FEAT_W-1:0] rd_feat,
    input  logic [2:0]        rd_idx,
    output logic [IN_W-1:0]   rd_data
);

    logic [IN_W-1:0] thr_q [NUM_FEAT][NUM_THR];
    logic            wr_hit;
    logic            rd_hit;

    // Qualify writes: real threshold slot of an existing feature only.
    always_comb begin
        wr_hit = wr_en && (wr_idx != 3'd0) && (32'(wr_feat) < NUM_FEAT);
        rd_hit = (rd_idx != 3'd0) && (32'(rd_feat) < NUM_FEAT);
    end

    // Threshold storage; cleared by reset so an unprogrammed feature maps every
    // non-zero sample to code 7.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned f = 0; f < NUM_FEAT; f++) begin
                for (int unsigned t = 0; t < NUM_THR; t++) begin
                    thr_q[f][t] <= '0;
                end
            end
        end else if (wr_hit) begin
            thr_q[wr_feat][wr_idx - 3'd1] <= wr_data;
        end
    end

    // Combinational read port used by the search.
    always_comb begin
        rd_data = '0;
        if (rd_hit) begin
            rd_data = thr_q[rd_feat][rd_idx - 3'd1];
        end
    end

endmodule

// File: rtl/feature_quantizer_3b.sv
// Streaming 3-bit feature quantizer. Each sample is compared against its
// feature's seven thresholds with a 3-step successive-approximation search
// (one compare per cycle), giving the count of thresholds strictly exceeded
// when the table is sorted.
// Optional: define FQ_STATS_EN to add saturating code-0 / code-7 counters.
module feature_quantizer_3b
    import fq_pkg::*;
#(
    parameter int unsigned IN_W     = 8,
    parameter int unsigned NUM_FEAT = 11,
    parameter int unsigned FEAT_W   = $clog2(NUM_FEAT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FEAT_W-1:0] in_feat,
    input  logic [IN_W-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FEAT_W-1:0] out_feat,
    output logic [CODE_W-1:0] out_code,
    input  logic              cfg_we,
    output logic              cfg_ready,
    input  logic [FEAT_W-1:0] cfg_feat,
    input  logic [2:0]        cfg_idx,
    input  logic [IN_W-1:0]   cfg_data
`ifdef FQ_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [STAT_W-1:0] sat_lo_cnt,
    output logic [STAT_W-1:0] sat_hi_cnt
`endif
);

    fq_state_t         state_q, state_d;
    logic [IN_W-1:0]   x_q;
    logic [FEAT_W-1:0] f_q;
    logic              c2_q;
    logic              c1_q;
    logic [FEAT_W-1:0] out_feat_q;
    logic [CODE_W-1:0] out_code_q;

    logic              accept;
    logic              cfg_take;
    logic [2:0]        rd_idx;
    logic [IN_W-1:0]   thr_rd;
    logic              gt;

    // Handshakes and the write guard protecting the feature under search.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == OUT);
        accept    = in_valid && in_ready;
        cfg_ready = !((state_q != IDLE) && (cfg_feat == f_q));
        cfg_take  = cfg_we && cfg_ready;
        out_feat  = out_feat_q;
        out_code  = out_code_q;
    end

    fq_thr_bank #(
        .IN_W     (IN_W),
        .NUM_FEAT (NUM_FEAT),
        .FEAT_W   (FEAT_W)
    ) u_thr_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (cfg_take),
        .wr_feat (cfg_feat),
        .wr_idx  (cfg_idx),
        .wr_data (cfg_data),
        .rd_feat (f_q),
        .rd_idx  (rd_idx),
        .rd_data (thr_rd)
    );

    // Pick the threshold to probe from the bits already resolved.
    always_comb begin
        rd_idx = 3'd4;
        case (state_q)
            S1:      rd_idx = c2_q ? 3'd6 : 3'd2;
            S0:      rd_idx = {c2_q, c1_q, 1'b1};
            default: rd_idx = 3'd4;
        endcase
        // Strict compare: a sample equal to a threshold rounds down.
        gt = (x_q > thr_rd);
    end

    // Next-state logic for the search sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = S2;
            S2:      state_d = S1;
            S1:      state_d = S0;
            S0:      state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sample capture and code bits; outputs only change on entering OUT so they
    // hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q        <= '0;
            f_q        <= '0;
            c2_q       <= 1'b0;
            c1_q       <= 1'b0;
            out_feat_q <= '0;
            out_code_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        x_q <= in_data;
                        f_q <= in_feat;
                    end
                end
                S2: c2_q <= gt;
                S1: c1_q <= gt;
                S0: begin
                    out_code_q <= {c2_q, c1_q, gt};
                    out_feat_q <= f_q;
                end
                default: ;
            endcase
        end
    end

`ifdef FQ_STATS_EN
    logic              out_hs;
    logic [STAT_W-1:0] lo_q;
    logic [STAT_W-1:0] hi_q;

    always_comb begin
        out_hs     = out_valid && out_ready;
        sat_lo_cnt = lo_q;
        sat_hi_cnt = hi_q;
    end

    // Saturating extreme-code counters; a clear beats a coincident count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q <= '0;
            hi_q <= '0;
        end else if (stats_clr) begin
            lo_q <= '0;
            hi_q <= '0;
        end else if (out_hs) begin
            if (out_code_q == 3'd0) lo_q <= sat_inc(lo_q);
            if (out_code_q == 3'd7) hi_q <= sat_inc(hi_q);
        end
    end
`endif

endmodule

// File: tb/tb_feature_quantizer_3b.sv
// Self-checking bench for feature_quantizer_3b: directed cases plus randomized
// traffic against a threshold-table model. Exercises FQ_STATS_EN when defined.
module tb_feature_quantizer_3b;

    localparam int IN_W     = 8;
    localparam int NUM_FEAT = 11;
    localparam int FEAT_W   = $clog2(NUM_FEAT);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [FEAT_W-1:0] in_feat = '0;
    logic [IN_W-1:0]   in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [FEAT_W-1:0] out_feat;
    logic [2:0]        out_code;
    logic              cfg_we = 1'b0;
    logic              cfg_ready;
    logic [FEAT_W-1:0] cfg_feat = '0;
    logic [2:0]        cfg_idx = '0;
    logic [IN_W-1:0]   cfg_data = '0;
`ifdef FQ_STATS_EN
    logic              stats_clr = 1'b0;
    logic [15:0]       sat_lo_cnt;
    logic [15:0]       sat_hi_cnt;
    int                lo_m = 0;
    int                hi_m = 0;
`endif

    int checks = 0;
    int errors = 0;

    // Model: thr_m[f][k] is threshold k (1..7) of feature f.
    int thr_m [NUM_FEAT][8];

    always #5 clk = ~clk;

    feature_quantizer_3b dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_feat    (in_feat),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_feat   (out_feat),
        .out_code   (out_code),
        .cfg_we     (cfg_we),
        .cfg_ready  (cfg_ready),
        .cfg_feat   (cfg_feat),
        .cfg_idx    (cfg_idx),
        .cfg_data   (cfg_data)
`ifdef FQ_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .sat_lo_cnt (sat_lo_cnt),
        .sat_hi_cnt (sat_hi_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void clear_model();
        for (int f = 0; f < NUM_FEAT; f++)
            for (int k = 0; k < 8; k++) thr_m[f][k] = 0;
    endfunction

    // Code defined by the search rule; valid for any table.
    function automatic int search_code(input int f, input int x);
        int b2, b1, b0;
        b2 = (x > thr_m[f][4]) ? 1 : 0;
        b1 = (x > thr_m[f][b2 ? 6 : 2]) ? 1 : 0;
        b0 = (x > thr_m[f][4 * b2 + 2 * b1 + 1]) ? 1 : 0;
        return 4 * b2 + 2 * b1 + b0;
    endfunction

    // Code for a sorted table: number of thresholds strictly below the sample.
    function automatic int count_above(input int f, input int x);
        int n = 0;
        for (int k = 1; k <= 7; k++) if (x > thr_m[f][k]) n++;
        return n;
    endfunction

    function automatic bit is_sorted(input int f);
        for (int k = 1; k < 7; k++) if (thr_m[f][k] > thr_m[f][k + 1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_model();
`ifdef FQ_STATS_EN
        lo_m = 0;
        hi_m = 0;
`endif
    endtask

    task automatic cfg_write(input int f, input int idx, input int d);
        int n = 0;
        cfg_we   = 1'b1;
        cfg_feat = FEAT_W'(f);
        cfg_idx  = 3'(idx);
        cfg_data = IN_W'(d);
        #1;
        while (!cfg_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("cfg_ready_wait", cfg_ready, 1);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        if (idx != 0) thr_m[f][idx] = d;
    endtask

    // One sample end to end: latency, code, feature, optional backpressure.
    task automatic send(input int f, input int x, input int exp, input int hold, input bit clr);
        int n = 0;
        in_valid = 1'b1;
        in_feat  = FEAT_W'(f);
        in_data  = IN_W'(x);
        #1;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        chk("busy_in_ready", in_ready, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("latency_early", out_valid, 0);
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        chk("latency_valid", out_valid, 1);
        chk("out_code", out_code, exp);
        chk("out_feat", out_feat, f);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_code", out_code, exp);
            chk("bp_feat", out_feat, f);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
`ifdef FQ_STATS_EN
        stats_clr = clr;
`endif
        @(posedge clk);
        #1;
`ifdef FQ_STATS_EN
        stats_clr = 1'b0;
        if (clr) begin
            lo_m = 0;
            hi_m = 0;
        end else begin
            if (exp == 0) lo_m++;
            if (exp == 7) hi_m++;
        end
`endif
        chk("back_idle", in_ready, 1);
        chk("drop_valid", out_valid, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int f, x, exp, v;
        do_reset();

        // Reset values, all-zero thresholds.
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_code", out_code, 0);
        chk("rst_out_feat", out_feat, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        send(0, 0, 0, 0, 1'b0);
        send(0, 5, 7, 0, 1'b0);

        // Sorted table on feature 3, strict compare at boundaries.
        for (int k = 1; k <= 7; k++) cfg_write(3, k, 10 * k);
        send(3, 35, 3, 0, 1'b0);
        send(3, 70, 6, 0, 1'b0);
        send(3, 71, 7, 0, 1'b0);
        send(3, 10, 0, 0, 1'b0);
        send(3, 11, 1, 0, 1'b0);

        // Backpressure for 6 cycles.
        send(3, 35, 3, 6, 1'b0);

        // Index 0 writes are dropped.
        cfg_write(3, 0, 200);
        send(3, 11, 1, 0, 1'b0);

        // Write and accept in the same cycle: search sees the new value.
        cfg_we = 1'b1;
        cfg_feat = 2;
        cfg_idx = 4;
        cfg_data = 200;
        thr_m[2][4] = 200;
        send(2, 150, 3, 0, 1'b0);

        // Write guard during a feature-3 search.
        in_valid = 1'b1;
        in_feat  = 3;
        in_data  = 45;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_we   = 1'b1;
        cfg_feat = 4;
        cfg_idx  = 1;
        cfg_data = 99;
        #1;
        chk("cfg_other_feat", cfg_ready, 1);
        @(posedge clk);
        #1;
        thr_m[4][1] = 99;
        cfg_feat = 3;
        cfg_idx  = 5;
        cfg_data = 40;
        #1;
        chk("cfg_guard_s1", cfg_ready, 0);
        @(posedge clk);
        #1;
        chk("cfg_guard_s0", cfg_ready, 0);
        @(posedge clk);
        #1;
        chk("cfg_guard_out", cfg_ready, 0);
        chk("guard_old_code", out_code, 4);
        @(posedge clk);
        #1;
        chk("cfg_guard_idle", cfg_ready, 1);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        thr_m[3][5] = 40;
        send(3, 45, 5, 0, 1'b0);
        send(4, 100, search_code(4, 100), 0, 1'b0);

        // Randomized traffic, sorted and unsorted tables.
        for (int it = 0; it < 60; it++) begin
            f = $urandom_range(0, NUM_FEAT - 1);
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 3) != 0) begin
                    v = $urandom_range(0, 30);
                    for (int k = 1; k <= 7; k++) begin
                        cfg_write(f, k, v);
                        v = v + $urandom_range(0, 40);
                        if (v > 255) v = 255;
                    end
                end else begin
                    for (int k = 1; k <= 7; k++) cfg_write(f, k, $urandom_range(0, 255));
                end
                if ($urandom_range(0, 3) == 0) cfg_write(f, 0, $urandom_range(0, 255));
            end
            if ($urandom_range(0, 1) == 0) begin
                x = thr_m[f][$urandom_range(1, 7)] + $urandom_range(0, 2) - 1;
                if (x < 0) x = 0;
                if (x > 255) x = 255;
            end else begin
                x = $urandom_range(0, 255);
            end
            exp = is_sorted(f) ? count_above(f, x) : search_code(f, x);
            send(f, x, exp, $urandom_range(0, 2), 1'b0);
        end

        // Asynchronous reset mid-search.
        in_valid = 1'b1;
        in_feat  = 3;
        in_data  = 45;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        do_reset();
        send(3, 5, 7, 0, 1'b0);
        send(3, 0, 0, 0, 1'b0);

`ifdef FQ_STATS_EN
        do_reset();
        #1;
        chk("stats_rst_lo", sat_lo_cnt, 0);
        chk("stats_rst_hi", sat_hi_cnt, 0);
        for (int i = 0; i < 3; i++) send(i, 0, 0, i, 1'b0);
        for (int i = 0; i < 2; i++) send(5, 200, 7, 0, 1'b0);
        chk("stats_lo", sat_lo_cnt, 3);
        chk("stats_hi", sat_hi_cnt, 2);
        chk("stats_lo_model", sat_lo_cnt, lo_m);
        send(1, 0, 0, 0, 1'b1);
        chk("stats_clr_lo", sat_lo_cnt, 0);
        chk("stats_clr_hi", sat_hi_cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
